// File: rtl/timer_irq_unit.sv
// Machine-level interrupt source: 64-bit mtime/mtimecmp timer, software bit and
// synchronised edge-latched external line, behind a 32-byte load/store window.
module timer_irq_unit #(
  parameter logic [31:0] BASE_ADDR = 32'hFFFF_0000,
  parameter int unsigned PRESCALE  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ext_irq,
  input  logic [31:0] bus_addr,
  input  logic [31:0] bus_wdata,
  input  logic        bus_we,
  input  logic        bus_re,
  output logic [31:0] bus_rdata,
  output logic        bus_hit,
  output logic        interrupt,
  output logic [4:0]  irq_code
);

  localparam logic [15:0] PSC_LAST       = 16'(PRESCALE - 1);
  localparam logic [2:0]  OFF_MSIP       = 3'd0;
  localparam logic [2:0]  OFF_EXT_PEND   = 3'd1;
  localparam logic [2:0]  OFF_IRQ_EN     = 3'd2;
  localparam logic [2:0]  OFF_MTIME_LO   = 3'd4;
  localparam logic [2:0]  OFF_MTIME_HI   = 3'd5;
  localparam logic [2:0]  OFF_MTIMECMP_LO = 3'd6;
  localparam logic [2:0]  OFF_MTIMECMP_HI = 3'd7;

  logic [63:0] mtime_q, mtime_d;
  logic [63:0] mtimeCmp_q, mtimeCmp_d;
  logic [31:0] mtimeHiShadow_q, mtimeHiShadow_d;
  logic [15:0] psc_q, psc_d;
  logic        msip_q, msip_d;
  logic        extPend_q, extPend_d;
  logic [2:0]  irqEn_q, irqEn_d;
  logic        s1_q, s2_q, s3_q;
  logic        interrupt_q, interrupt_d;
  logic [4:0]  irqCode_q, irqCode_d;

  logic [2:0]  offset;
  logic        wrEn, rdEn, pscWrap, extRise, extClear;
  logic [2:0]  active;
  logic        unusedAddrBits;

  assign offset         = bus_addr[4:2];
  assign bus_hit        = (bus_addr[31:5] == BASE_ADDR[31:5]);
  assign wrEn           = bus_we & bus_hit;
  assign rdEn           = bus_re & bus_hit;
  assign unusedAddrBits = ^bus_addr[1:0];
  assign pscWrap        = (psc_q == PSC_LAST);
  assign extRise        = s2_q & ~s3_q;
  assign active         = {extPend_q, (mtime_q >= mtimeCmp_q), msip_q} & irqEn_q;

  always_comb begin
    bus_rdata = '0;
    if (rdEn) begin
      case (offset)
        OFF_MSIP:        bus_rdata = {31'd0, msip_q};
        OFF_EXT_PEND:    bus_rdata = {31'd0, extPend_q};
        OFF_IRQ_EN:      bus_rdata = {29'd0, irqEn_q};
        OFF_MTIME_LO:    bus_rdata = mtime_q[31:0];
        // The high half always comes from the shadow so a lo/hi pair is coherent.
        OFF_MTIME_HI:    bus_rdata = mtimeHiShadow_q;
        OFF_MTIMECMP_LO: bus_rdata = mtimeCmp_q[31:0];
        OFF_MTIMECMP_HI: bus_rdata = mtimeCmp_q[63:32];
        default:         bus_rdata = '0;
      endcase
    end
  end

  always_comb begin
    psc_d           = pscWrap ? 16'd0 : psc_q + 16'd1;
    mtime_d         = mtime_q + {63'd0, pscWrap};
    mtimeCmp_d      = mtimeCmp_q;
    mtimeHiShadow_d = mtimeHiShadow_q;
    msip_d          = msip_q;
    irqEn_d         = irqEn_q;
    extClear        = 1'b0;
    if (wrEn) begin
      case (offset)
        OFF_MSIP:        msip_d = bus_wdata[0];
        OFF_EXT_PEND:    extClear = bus_wdata[0];
        OFF_IRQ_EN:      irqEn_d = bus_wdata[2:0];
        OFF_MTIME_LO:    mtime_d = {mtime_q[63:32], bus_wdata};
        OFF_MTIME_HI:    mtime_d = {bus_wdata, mtime_q[31:0]};
        OFF_MTIMECMP_LO: mtimeCmp_d = {mtimeCmp_q[63:32], bus_wdata};
        OFF_MTIMECMP_HI: mtimeCmp_d = {bus_wdata, mtimeCmp_q[31:0]};
        default:         extClear = 1'b0;
      endcase
    end
    if (rdEn && offset == OFF_MTIME_LO) begin
      mtimeHiShadow_d = mtime_q[63:32];
    end
    // A freshly detected edge beats a simultaneous write-one-to-clear.
    extPend_d   = extRise | (extPend_q & ~extClear);
    interrupt_d = |active;
    if (active[2])      irqCode_d = 5'd11;
    else if (active[0]) irqCode_d = 5'd3;
    else if (active[1]) irqCode_d = 5'd7;
    else                irqCode_d = 5'd0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mtime_q         <= '0;
      mtimeCmp_q      <= '1;
      mtimeHiShadow_q <= '0;
      psc_q           <= '0;
      msip_q          <= 1'b0;
      extPend_q       <= 1'b0;
      irqEn_q         <= '0;
      s1_q            <= 1'b0;
      s2_q            <= 1'b0;
      s3_q            <= 1'b0;
      interrupt_q     <= 1'b0;
      irqCode_q       <= '0;
    end else begin
      mtime_q         <= mtime_d;
      mtimeCmp_q      <= mtimeCmp_d;
      mtimeHiShadow_q <= mtimeHiShadow_d;
      psc_q           <= psc_d;
      msip_q          <= msip_d;
      extPend_q       <= extPend_d;
      irqEn_q         <= irqEn_d;
      s1_q            <= ext_irq;
      s2_q            <= s1_q;
      s3_q            <= s2_q;
      interrupt_q     <= interrupt_d;
      irqCode_q       <= irqCode_d;
    end
  end

  assign interrupt = interrupt_q;
  assign irq_code  = irqCode_q;

endmodule

// File: tb/tb_timer_irq_unit.sv
// Scoreboard bench for timer_irq_unit: two instances (PRESCALE 1 and 3) share
// randomized and directed bus/ext stimulus, checked against a behavioural model.
module tb_timer_irq_unit;

  localparam logic [31:0] BASE = 32'hFFFF_0000;
  localparam logic [31:0] MASK = 32'hFFFF_FFE0;

  logic        clk = 1'b0;
  logic        rst, ext_irq, bus_we, bus_re;
  logic [31:0] bus_addr, bus_wdata;
  logic [31:0] rdataA, rdataB;
  logic        hitA, hitB, irqA, irqB;
  logic [4:0]  codeA, codeB;

  timer_irq_unit #(.BASE_ADDR(BASE), .PRESCALE(1)) dutA (
    .clk(clk), .rst(rst), .ext_irq(ext_irq), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_we(bus_we), .bus_re(bus_re),
    .bus_rdata(rdataA), .bus_hit(hitA), .interrupt(irqA), .irq_code(codeA));

  timer_irq_unit #(.BASE_ADDR(BASE), .PRESCALE(3)) dutB (
    .clk(clk), .rst(rst), .ext_irq(ext_irq), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_we(bus_we), .bus_re(bus_re),
    .bus_rdata(rdataB), .bus_hit(hitB), .interrupt(irqB), .irq_code(codeB));

  always #5 clk = ~clk;

  typedef struct packed {
    logic        hit;
    logic [31:0] rd0;
    logic [31:0] rd1;
  } busExp_t;

  typedef struct packed {
    logic [5:0] irq0;
    logic [5:0] irq1;
  } irqExp_t;

  busExp_t busQ[$];
  irqExp_t irqQ[$];
  int total = 0;
  int bad   = 0;
  logic extLevel = 1'b0;

  // Reference model: architectural register contents after the latest edge.
  logic [63:0] mMtime [2];
  logic [31:0] mShadow [2];
  int          mEdges [2];
  int          prescale [2] = '{1, 3};
  logic [63:0] mCmp;
  logic        mMsip, mExtPend;
  logic [2:0]  mEn;
  logic        mExtSeen [3];

  function automatic logic [31:0] modelRead(int d, logic [31:0] a, logic re);
    if (!re || (a & MASK) != BASE) return 32'd0;
    case (a[4:2])
      3'd0: return {31'd0, mMsip};
      3'd1: return {31'd0, mExtPend};
      3'd2: return {29'd0, mEn};
      3'd4: return mMtime[d][31:0];
      3'd5: return mShadow[d];
      3'd6: return mCmp[31:0];
      3'd7: return mCmp[63:32];
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [5:0] modelIrq(int d);
    logic [2:0] act;
    act = {mExtPend, mMtime[d] >= mCmp, mMsip} & mEn;
    if (act[2]) return {1'b1, 5'd11};
    if (act[0]) return {1'b1, 5'd3};
    if (act[1]) return {1'b1, 5'd7};
    return 6'd0;
  endfunction

  task automatic modelEdge(input logic r, input logic we, input logic re,
                           input logic [31:0] a, input logic [31:0] wd, input logic e);
    logic wr, rd, rise, clr;
    logic [2:0] off;
    if (r) begin
      for (int d = 0; d < 2; d++) begin
        mMtime[d] = 64'd0; mShadow[d] = 32'd0; mEdges[d] = 0;
      end
      mCmp = '1; mMsip = 1'b0; mExtPend = 1'b0; mEn = 3'd0;
      for (int k = 0; k < 3; k++) mExtSeen[k] = 1'b0;
      return;
    end
    off = a[4:2];
    wr  = we && ((a & MASK) == BASE);
    rd  = re && ((a & MASK) == BASE);
    // ext level sampled two edges ago is high, three edges ago low.
    rise = mExtSeen[1] & ~mExtSeen[2];
    mExtSeen[2] = mExtSeen[1];
    mExtSeen[1] = mExtSeen[0];
    mExtSeen[0] = e;
    for (int d = 0; d < 2; d++) begin
      if (rd && off == 3'd4) mShadow[d] = mMtime[d][63:32];
      mEdges[d]++;
      if (wr && off == 3'd4)      mMtime[d][31:0]  = wd;
      else if (wr && off == 3'd5) mMtime[d][63:32] = wd;
      else if (mEdges[d] % prescale[d] == 0) mMtime[d] = mMtime[d] + 64'd1;
    end
    clr = wr && off == 3'd1 && wd[0];
    if (wr) begin
      case (off)
        3'd0: mMsip = wd[0];
        3'd2: mEn = wd[2:0];
        3'd6: mCmp[31:0] = wd;
        3'd7: mCmp[63:32] = wd;
        default: ;
      endcase
    end
    mExtPend = rise | (mExtPend & ~clr);
  endtask

  task automatic applyStimulus(input logic r, input logic we, input logic re,
                               input logic [31:0] a, input logic [31:0] wd, input logic e);
    busExp_t be;
    irqExp_t ie;
    rst = r; bus_we = we; bus_re = re; bus_addr = a; bus_wdata = wd; ext_irq = e;
    be.hit = ((a & MASK) == BASE);
    be.rd0 = modelRead(0, a, re);
    be.rd1 = modelRead(1, a, re);
    busQ.push_back(be);
    @(posedge clk);
    ie.irq0 = r ? 6'd0 : modelIrq(0);
    ie.irq1 = r ? 6'd0 : modelIrq(1);
    irqQ.push_back(ie);
    modelEdge(r, we, re, a, wd, e);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic doWrite(input logic [2:0] off, input logic [31:0] wd);
    applyStimulus(1'b0, 1'b1, 1'b0, BASE | {27'd0, off, 2'b00}, wd, extLevel);
  endtask

  task automatic doRead(input logic [2:0] off);
    applyStimulus(1'b0, 1'b0, 1'b1, BASE | {27'd0, off, 2'b00}, 32'd0, extLevel);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, extLevel);
  endtask

  // Monitor: compares combinational bus outputs and registered irq outputs.
  busExp_t monBus;
  irqExp_t monIrq;
  always @(negedge clk) begin
    if (busQ.size() > 0) begin
      monBus = busQ.pop_front();
      checkOutput("hitP1", {31'd0, hitA}, {31'd0, monBus.hit});
      checkOutput("hitP3", {31'd0, hitB}, {31'd0, monBus.hit});
      checkOutput("rdataP1", rdataA, monBus.rd0);
      checkOutput("rdataP3", rdataB, monBus.rd1);
    end
    if (irqQ.size() > 0) begin
      monIrq = irqQ.pop_front();
      checkOutput("irqP1", {26'd0, irqA, codeA}, {26'd0, monIrq.irq0});
      checkOutput("irqP3", {26'd0, irqB, codeB}, {26'd0, monIrq.irq1});
    end
  end

  initial begin
    logic [2:0]  off;
    logic [31:0] a, wd;
    int k;
    rst = 1'b1; ext_irq = 1'b0; bus_we = 1'b0; bus_re = 1'b0;
    bus_addr = 32'd0; bus_wdata = 32'd0;
    @(posedge clk);
    #1;
    applyStimulus(1'b1, 1'b0, 1'b0, BASE, 32'd0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, BASE, 32'd0, 1'b0);
    for (int i = 0; i < 8; i++) doRead(3'(i));

    // Timer match at mtime == 20, then cleared by moving mtimecmp.
    doWrite(3'd2, 32'd2);
    doWrite(3'd7, 32'd0);
    doWrite(3'd6, 32'd20);
    doWrite(3'd5, 32'd0);
    doWrite(3'd4, 32'd0);
    for (int i = 0; i < 25; i++) doRead(3'd4);
    doWrite(3'd6, 32'd100);
    idle(3);

    // Coherent mtime read across the low-word carry.
    doWrite(3'd5, 32'd0);
    doWrite(3'd4, 32'hFFFF_FFFF);
    doRead(3'd4);
    doRead(3'd5);
    doRead(3'd4);
    doRead(3'd5);

    // External edge overrides sw/timer; W1C racing a new edge loses.
    doWrite(3'd2, 32'd7);
    doWrite(3'd0, 32'd1);
    doWrite(3'd7, 32'd0);
    doWrite(3'd6, 32'd0);
    idle(4);
    extLevel = 1'b1;
    idle(5);
    doWrite(3'd1, 32'd1);
    extLevel = 1'b0;
    idle(3);
    doRead(3'd1);
    extLevel = 1'b1;
    idle(2);
    doWrite(3'd1, 32'd1);
    doRead(3'd1);
    idle(1);
    doWrite(3'd1, 32'd1);
    doRead(3'd1);

    // mtime wrap at all-ones, then reset racing a msip store.
    doWrite(3'd5, 32'hFFFF_FFFF);
    doWrite(3'd4, 32'hFFFF_FFFF);
    for (int i = 0; i < 4; i++) doRead(3'd4);
    applyStimulus(1'b1, 1'b1, 1'b0, BASE, 32'd1, extLevel);
    doRead(3'd0);

    // Out-of-window and reserved accesses leave state untouched.
    applyStimulus(1'b0, 1'b1, 1'b0, BASE + 32'h20, 32'd1, extLevel);
    applyStimulus(1'b0, 1'b0, 1'b1, BASE + 32'h20, 32'd0, extLevel);
    applyStimulus(1'b0, 1'b1, 1'b0, BASE + 32'h24, 32'd7, extLevel);
    doWrite(3'd3, 32'hFFFF_FFFF);
    doRead(3'd3);
    for (int i = 0; i < 8; i++) doRead(3'(i));

    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 7) == 0) extLevel = ~extLevel;
      off = 3'($urandom_range(0, 7));
      a = BASE | {27'd0, off, 2'($urandom_range(0, 3))};
      if ($urandom_range(0, 15) == 0) a = BASE + 32'h20 + 32'($urandom_range(0, 31));
      if ($urandom_range(0, 31) == 0) a = $urandom;
      if (off >= 3'd4)
        wd = (off[0] == 1'b1) ? (($urandom_range(0, 7) == 0) ? $urandom : 32'd0)
                              : 32'($urandom_range(0, 400));
      else
        wd = $urandom;
      k = $urandom_range(0, 199);
      if (k < 2)        applyStimulus(1'b1, 1'($urandom_range(0, 1)), 1'b0, a, wd, extLevel);
      else if (k < 70)  applyStimulus(1'b0, 1'b1, 1'b0, a, wd, extLevel);
      else if (k < 150) applyStimulus(1'b0, 1'b0, 1'b1, a, wd, extLevel);
      else              applyStimulus(1'b0, 1'b0, 1'b0, a, wd, extLevel);
    end

    @(negedge clk);
    #1;
    checkOutput("queueDrain", 32'(busQ.size() + irqQ.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/timer_irq_unit.md
# timer_irq_unit

Machine-level interrupt source for the pipelined core: holds a 64-bit `mtime` counter, a 64-bit `mtimecmp`, a software-interrupt bit and a synchronised, edge-latched external interrupt line. It sits upstream of the exception unit and drives that unit's `interrupt` input. Its memory-mapped registers are accessed from the MEM stage through a simple word-wide load/store port.

## Interface
Parameters:
- `BASE_ADDR`, default 32'hFFFF_0000: register window base; the window is 32 bytes.
- `PRESCALE`, default 1: clock cycles per `mtime` increment. Range 1..65535.

Ports:
- `clk`  in  1  system clock. One clock domain.
- `rst`  in  1  reset. Synchronous, active-high.
- `ext_irq`  in  1  asynchronous external interrupt request, level, active-high.
- `bus_addr`  in  32  MEM-stage byte address. Bits [1:0] are ignored.
- `bus_wdata`  in  32  store data (full word only).
- `bus_we`  in  1  store strobe.
- `bus_re`  in  1  load strobe.
- `bus_rdata`  out  32  load data, combinational.
- `bus_hit`  out  1  address lies in the window, combinational.
- `interrupt`  out  1  registered request to the exception unit.
- `irq_code`  out  5  registered cause code: 11 ext, 3 sw, 7 timer, 0 none.

## Operation
Register map, as byte offsets from `BASE_ADDR`:
- 0x00 `msip`: bit0 read/write; other bits read 0.
- 0x04 `ext_pend`: bit0 read-only. Writing 1 to bit0 clears it.
- 0x08 `irq_en`: bits[2:0] read/write. bit0 sw, bit1 timer, bit2 ext.
- 0x0C: reserved. Reads 0; writes ignored.
- 0x10 `mtime_lo`, 0x14 `mtime_hi`: read/write.
- 0x18 `mtimecmp_lo`, 0x1C `mtimecmp_hi`: read/write.

Bus rules:
- `bus_hit` is 1 when `bus_addr[31:5] == BASE_ADDR[31:5]`.
- When `bus_hit` is 0: `bus_rdata` = 0 and writes are ignored.
- `bus_rdata` = 0 whenever `bus_re` = 0.

mtime:
- A prescale counter counts 0..PRESCALE-1. On the wrap cycle, `mtime` increments by 1, modulo 2^64.
- A write to either `mtime` half replaces that half and suppresses the increment in that cycle. The prescale counter keeps running.

Atomic mtime read:
- A read of `mtime_lo` returns the live low word and latches the live high word into `mtime_hi_shadow` at the clock edge.
- A read of `mtime_hi` always returns `mtime_hi_shadow`, never the live high word.

Pending vector, evaluated from current register values:
- sw = `msip`
- timer = (`mtime` >= `mtimecmp`), 64-bit unsigned compare
- ext = `ext_pend`

External line:
- `ext_irq` passes through a 2-flop synchroniser (s1, s2), then a third flop s3.
- On a rising edge (s2 & ~s3), `ext_pend` is set.
- If a set and a W1C clear occur in the same cycle, the set wins.

Request output:
- Each cycle, `interrupt <= |(pend & irq_en)`.
- `irq_code` is registered with `interrupt`, using priority ext > sw > timer. It is 0 when `interrupt` = 0.
- `interrupt` is level-based. It stays high until software clears the source: `msip` write 0, `ext_pend` W1C, a `mtimecmp` write, or an `irq_en` change.

## Timing
- Reset values: `mtime` 0; `mtimecmp` 64'hFFFF_FFFF_FFFF_FFFF; `msip` 0; `irq_en` 0; `ext_pend` 0; s1/s2/s3 0; prescale counter 0; `mtime_hi_shadow` 0; `interrupt` 0; `irq_code` 0.
- Reset applied mid-operation returns every register to these values at the next edge, regardless of any concurrent bus write.
- Stores take effect at the clock edge ending the cycle in which `bus_we` = 1. Loads return data in the same cycle.
- With PRESCALE = 1, `mtime` increments every cycle. With PRESCALE = N, it increments on every Nth edge after reset.
- Timer path: `mtime` becomes >= `mtimecmp` after edge E, so `interrupt` = 1 after edge E+1 (when enabled).
- Software path: a `msip` store at edge E gives `interrupt` = 1 after edge E+1.
- External path: `ext_irq` rises before edge E. Then `ext_pend` = 1 after E+2, and `interrupt` = 1 after E+3.
- An `ext_irq` pulse shorter than one clock may be missed. A level held ≥ 2 cycles is never missed.
- `mtime` wrap from 2^64-1 to 0 produces no special event. The timer pending bit follows the compare.
- Writing `mtimecmp` halves non-atomically can cause a transient match. Software convention is to write `mtimecmp_hi` = all-ones first.

## Test plan
- Reset, then read every offset -> `mtime` 0/0, `mtimecmp` FFFFFFFF/FFFFFFFF, others 0; `interrupt` = 0.
- PRESCALE = 1: `irq_en` = 2, `mtimecmp` = {0, 20}, `mtime` = 0 -> `interrupt` = 1 and `irq_code` = 7 exactly one cycle after `mtime_lo` reads 20. Writing `mtimecmp_lo` = 100 -> `interrupt` = 0 one cycle later.
- `mtime` = {0, FFFFFFFF}, then read lo, then read hi after the carry -> lo returns FFFFFFFF and hi returns 0 (shadow). A second lo/hi pair returns the live values {1, x}.
- `irq_en` = 7; `ext_irq` rises while `msip` = 1 and the timer is pending -> `irq_code` changes from 3 to 11 three cycles after the rising edge. W1C to 0x04 in the cycle a new edge is detected -> `ext_pend` stays 1.
- `mtime` = all-ones with PRESCALE = 3 -> it wraps to 0 after 3 cycles. Asserting `rst` together with a store to `msip` -> `msip` = 0.
- Stores and loads to `BASE_ADDR` + 0x20 and to 0x0C -> `bus_hit` = 0 / `bus_rdata` = 0 for out-of-range, 0 for the reserved offset; no register changes.
